// File: rtl/capture_sequencer.sv
// Command-driven ADC capture sequencer: pops UDP command words, aligns to ADC framing,
// issues adc_buffer starts, counts tx_done packets per capture and watches for stalled transmit.
module capture_sequencer #(
    parameter int unsigned PKTS_PER_CAPTURE = 8,
    parameter int unsigned TIMEOUT_CYCLES   = 1250000,
    parameter int unsigned DEFAULT_GAP      = 125,
    parameter int unsigned GAP_W            = 24
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    input  logic [31:0] cmd_data,
    output logic        cmd_rd_en,
    input  logic        adc_aligned,
    input  logic        tx_done,
    output logic        start_buff,
    output logic        busy,
    output logic [15:0] capture_count,
    output logic        timeout_err,
    output logic        cmd_err
);

    localparam int unsigned TO_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]      PKT_LAST = 8'(PKTS_PER_CAPTURE - 1);
    localparam logic [7:0]      OP_START = 8'h01;
    localparam logic [7:0]      OP_STOP  = 8'h02;
    localparam logic [7:0]      OP_GAP   = 8'h03;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_ALIGN,
        ARM,
        WAIT_TX,
        GAP
    } state_t;

    state_t            r_state;
    logic              r_cmd_rd_en;
    logic              r_start_buff;
    logic              r_busy;
    logic [15:0]       r_capture_count;
    logic              r_timeout_err;
    logic              r_cmd_err;
    logic              r_stop_req;
    logic              r_continuous;
    logic [23:0]       r_remaining;
    logic [GAP_W-1:0]  r_gap_reg;
    logic [GAP_W-1:0]  r_gap_cnt;
    logic [7:0]        r_pkt_cnt;
    logic [TO_W-1:0]   r_to_cnt;
    logic              r_tx_done;
    logic              r_adc_aligned;

    logic [7:0]        w_opcode;
    logic [23:0]       w_arg;
    logic              w_dec_start;
    logic              w_dec_stop;
    logic              w_dec_gap;
    logic              w_dec_bad;
    logic              w_stop;
    logic              w_timeout;

    assign w_opcode    = cmd_data[31:24];
    assign w_arg       = cmd_data[23:0];
    assign w_dec_start = r_cmd_rd_en && (w_opcode == OP_START);
    assign w_dec_stop  = r_cmd_rd_en && (w_opcode == OP_STOP);
    assign w_dec_gap   = r_cmd_rd_en && (w_opcode == OP_GAP);
    assign w_dec_bad   = r_cmd_rd_en && (w_opcode != OP_START) &&
                         (w_opcode != OP_STOP) && (w_opcode != OP_GAP);
    // A STOP decoded this cycle must already block the next start_buff.
    assign w_stop      = r_stop_req || w_dec_stop;
    // The raw tx_done restarts the window, so expiry loses to a same-cycle packet.
    assign w_timeout   = (r_to_cnt == TO_LAST) && !tx_done && !r_tx_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= IDLE;
            r_cmd_rd_en     <= 1'b0;
            r_start_buff    <= 1'b0;
            r_busy          <= 1'b0;
            r_capture_count <= '0;
            r_timeout_err   <= 1'b0;
            r_cmd_err       <= 1'b0;
            r_stop_req      <= 1'b0;
            r_continuous    <= 1'b0;
            r_remaining     <= '0;
            r_gap_reg       <= GAP_W'(DEFAULT_GAP);
            r_gap_cnt       <= '0;
            r_pkt_cnt       <= '0;
            r_to_cnt        <= '0;
            r_tx_done       <= 1'b0;
            r_adc_aligned   <= 1'b0;
        end else begin
            r_cmd_rd_en   <= cmd_valid && !r_cmd_rd_en;
            r_start_buff  <= 1'b0;
            r_cmd_err     <= 1'b0;
            r_tx_done     <= tx_done && (r_state == WAIT_TX);
            r_adc_aligned <= adc_aligned;

            if (w_dec_gap) begin
                r_gap_reg <= w_arg[GAP_W-1:0];
            end
            if (w_dec_stop && (r_state != IDLE)) begin
                r_stop_req <= 1'b1;
            end
            if (w_dec_bad || (w_dec_start && (r_state != IDLE))) begin
                r_cmd_err <= 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if (w_dec_start) begin
                        r_capture_count <= '0;
                        r_timeout_err   <= 1'b0;
                        r_remaining     <= w_arg;
                        r_continuous    <= (w_arg == '0);
                        r_busy          <= 1'b1;
                        r_state         <= WAIT_ALIGN;
                    end
                end

                WAIT_ALIGN: begin
                    if (w_stop) begin
                        r_state    <= IDLE;
                        r_busy     <= 1'b0;
                        r_stop_req <= 1'b0;
                    end else if (r_adc_aligned) begin
                        r_state      <= ARM;
                        r_start_buff <= 1'b1;
                    end
                end

                ARM: begin
                    r_pkt_cnt <= '0;
                    r_to_cnt  <= TO_W'(1);
                    r_state   <= WAIT_TX;
                end

                WAIT_TX: begin
                    r_to_cnt <= tx_done ? TO_W'(1) : r_to_cnt + TO_W'(1);
                    if (r_tx_done) begin
                        if (r_pkt_cnt == PKT_LAST) begin
                            r_pkt_cnt <= '0;
                            if (r_capture_count != 16'hFFFF) begin
                                r_capture_count <= r_capture_count + 16'd1;
                            end
                            if (!r_continuous) begin
                                r_remaining <= r_remaining - 24'd1;
                            end
                            if (w_stop || (!r_continuous && (r_remaining == 24'd1))) begin
                                r_state    <= IDLE;
                                r_busy     <= 1'b0;
                                r_stop_req <= 1'b0;
                            end else if (r_gap_reg != '0) begin
                                r_gap_cnt <= r_gap_reg;
                                r_state   <= GAP;
                            end else begin
                                r_state <= WAIT_ALIGN;
                            end
                        end else begin
                            r_pkt_cnt <= r_pkt_cnt + 8'd1;
                        end
                    end else if (w_timeout) begin
                        r_timeout_err <= 1'b1;
                        r_state       <= IDLE;
                        r_busy        <= 1'b0;
                        r_stop_req    <= 1'b0;
                    end
                end

                GAP: begin
                    if (w_stop) begin
                        r_state    <= IDLE;
                        r_busy     <= 1'b0;
                        r_stop_req <= 1'b0;
                    end else if (r_gap_cnt <= GAP_W'(1)) begin
                        r_state <= WAIT_ALIGN;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - GAP_W'(1);
                    end
                end

                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_rd_en     = r_cmd_rd_en;
    assign start_buff    = r_start_buff;
    assign busy          = r_busy;
    assign capture_count = r_capture_count;
    assign timeout_err   = r_timeout_err;
    assign cmd_err       = r_cmd_err;

endmodule

// File: tb/tb_capture_sequencer.sv
// Directed self-checking bench for capture_sequencer: burst counts, gap/align latency,
// STOP handling, command errors, transmit timeout and asynchronous reset.
module tb_capture_sequencer;

    localparam int unsigned PKTS = 8;
    localparam int unsigned TOUT = 100;
    localparam int unsigned DGAP = 125;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic [31:0] cmd_data;
    logic        cmd_rd_en;
    logic        adc_aligned;
    logic        tx_done;
    logic        start_buff;
    logic        busy;
    logic [15:0] capture_count;
    logic        timeout_err;
    logic        cmd_err;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int sb_count = 0;
    int sb_cyc   = 0;
    int err_count = 0;

    capture_sequencer #(
        .PKTS_PER_CAPTURE (PKTS),
        .TIMEOUT_CYCLES   (TOUT),
        .DEFAULT_GAP      (DGAP),
        .GAP_W            (24)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cmd_valid     (cmd_valid),
        .cmd_data      (cmd_data),
        .cmd_rd_en     (cmd_rd_en),
        .adc_aligned   (adc_aligned),
        .tx_done       (tx_done),
        .start_buff    (start_buff),
        .busy          (busy),
        .capture_count (capture_count),
        .timeout_err   (timeout_err),
        .cmd_err       (cmd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (start_buff) begin
            sb_count <= sb_count + 1;
            sb_cyc   <= cyc;
        end
        if (cmd_err) err_count <= err_count + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Returns #1 into the cycle after the decode cycle; dec is the cycle cmd_rd_en was high.
    task automatic send_cmd(input logic [31:0] w, output int dec);
        bit seen;
        seen = 1'b0;
        dec = -1;
        cmd_valid = 1'b1;
        cmd_data  = w;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (cmd_rd_en) begin
                seen = 1'b1;
                dec = cyc;
                break;
            end
        end
        check_val("cmd_pop", 32'(seen), 32'd1);
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        cmd_data = '0;
    endtask

    // n tx_done pulses ~31 cycles apart; returns #1 into the cycle after the last pulse.
    task automatic tx_burst(input int n, output int last);
        last = 0;
        for (int i = 0; i < n; i++) begin
            repeat (30) @(posedge clk);
            #1;
            tx_done = 1'b1;
            last = cyc;
            @(posedge clk); #1;
            tx_done = 1'b0;
        end
    endtask

    task automatic wait_sb(input string tag, input int budget);
        int base;
        bit seen;
        base = sb_count;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #1;
            if (sb_count != base) begin
                seen = 1'b1;
                break;
            end
        end
        check_val(tag, 32'(seen), 32'd1);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int d;
        int m;
        int sb0;
        int e0;
        int a;

        rst_n = 1'b0;
        cmd_valid = 1'b0;
        cmd_data = '0;
        adc_aligned = 1'b1;
        tx_done = 1'b0;
        step(3);
        check_val("rst_rd_en", 32'(cmd_rd_en), 32'd0);
        check_val("rst_start", 32'(start_buff), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_count", 32'(capture_count), 32'd0);
        check_val("rst_tout", 32'(timeout_err), 32'd0);
        check_val("rst_cmderr", 32'(cmd_err), 32'd0);
        rst_n = 1'b1;
        step(3);

        // Two bounded captures with the reset gap
        sb0 = sb_count;
        send_cmd(32'h0100_0002, d);
        wait_sb("t1_sb1", 20);
        check_val("t1_start_lat", 32'(sb_cyc), 32'(d + 2));
        tx_burst(8, m);
        wait_sb("t1_sb2", 400);
        check_val("t1_gap_lat", 32'(sb_cyc), 32'(m + DGAP + 3));
        tx_burst(8, m);
        check_val("t1_busy_hold", 32'(busy), 32'd1);
        step(1);
        check_val("t1_busy_fall", 32'(busy), 32'd0);
        step(300);
        check_val("t1_sb_total", 32'(sb_count - sb0), 32'd2);
        check_val("t1_count", 32'(capture_count), 32'd2);

        // Continuous run stopped during the third capture
        sb0 = sb_count;
        send_cmd(32'h0100_0000, d);
        wait_sb("t2_sb1", 20);
        check_val("t2_count_clr", 32'(capture_count), 32'd0);
        tx_burst(8, m);
        wait_sb("t2_sb2", 400);
        tx_burst(8, m);
        wait_sb("t2_sb3", 400);
        tx_burst(3, m);
        send_cmd(32'h0200_0000, d);
        tx_burst(5, m);
        step(1);
        check_val("t2_busy", 32'(busy), 32'd0);
        step(300);
        check_val("t2_sb_total", 32'(sb_count - sb0), 32'd3);
        check_val("t2_count", 32'(capture_count), 32'd3);

        // Late alignment
        adc_aligned = 1'b0;
        step(2);
        sb0 = sb_count;
        send_cmd(32'h0100_0001, d);
        step(500);
        check_val("t3_no_sb", 32'(sb_count - sb0), 32'd0);
        check_val("t3_busy_wait", 32'(busy), 32'd1);
        adc_aligned = 1'b1;
        a = cyc;
        wait_sb("t3_sb", 20);
        check_val("t3_align_lat", 32'(sb_cyc), 32'(a + 2));
        tx_burst(8, m);
        step(2);
        check_val("t3_tout", 32'(timeout_err), 32'd0);
        check_val("t3_count", 32'(capture_count), 32'd1);

        // Transmit stall
        send_cmd(32'h0100_0001, d);
        wait_sb("t4_sb", 20);
        tx_burst(3, m);
        step(int'(TOUT) - 2);
        check_val("t4_tout_early", 32'(timeout_err), 32'd0);
        check_val("t4_busy_early", 32'(busy), 32'd1);
        step(1);
        check_val("t4_tout_set", 32'(timeout_err), 32'd1);
        check_val("t4_busy", 32'(busy), 32'd0);
        check_val("t4_count", 32'(capture_count), 32'd0);
        tx_done = 1'b1;
        step(1);
        tx_done = 1'b0;
        step(3);
        check_val("t4_idle_tx", 32'(capture_count), 32'd0);

        // Rejected commands
        sb0 = sb_count;
        e0 = err_count;
        send_cmd(32'h0100_0001, d);
        wait_sb("t5_sb", 20);
        check_val("t5_tout_clr", 32'(timeout_err), 32'd0);
        tx_burst(2, m);
        send_cmd(32'h0100_0005, d);
        check_val("t5_err_start", 32'(cmd_err), 32'd1);
        step(1);
        check_val("t5_err_pulse", 32'(cmd_err), 32'd0);
        send_cmd(32'h7F00_0000, d);
        check_val("t5_err_op", 32'(cmd_err), 32'd1);
        tx_burst(6, m);
        step(3);
        check_val("t5_count", 32'(capture_count), 32'd1);
        check_val("t5_busy", 32'(busy), 32'd0);
        check_val("t5_errs", 32'(err_count - e0), 32'd2);
        send_cmd(32'h0200_0000, d);
        check_val("t5_stop_idle", 32'(cmd_err), 32'd0);
        send_cmd(32'h0100_0001, d);
        wait_sb("t5_after_stop", 20);
        tx_burst(8, m);
        step(3);
        check_val("t5_sb_total", 32'(sb_count - sb0), 32'd2);

        // Zero gap, then asynchronous reset mid-capture
        send_cmd(32'h0100_0000, d);
        wait_sb("t6_sb1", 20);
        tx_burst(2, m);
        send_cmd(32'h0300_0000, d);
        tx_burst(6, m);
        wait_sb("t6_sb2", 20);
        check_val("t6_gap0_lat", 32'(sb_cyc), 32'(m + 3));
        tx_burst(2, m);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check_val("t6_rst_busy", 32'(busy), 32'd0);
        check_val("t6_rst_count", 32'(capture_count), 32'd0);
        check_val("t6_rst_start", 32'(start_buff), 32'd0);
        check_val("t6_rst_rd_en", 32'(cmd_rd_en), 32'd0);
        step(2);
        rst_n = 1'b1;
        step(2);
        sb0 = sb_count;
        send_cmd(32'h0100_0002, d);
        wait_sb("t6_sb3", 20);
        tx_burst(8, m);
        wait_sb("t6_sb4", 400);
        check_val("t6_gap_default", 32'(sb_cyc), 32'(m + DGAP + 3));
        tx_burst(8, m);
        step(3);
        check_val("t6_count", 32'(capture_count), 32'd2);
        check_val("t6_sb_total", 32'(sb_count - sb0), 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
